awsctrl_rx: RTL
===============

AWSCTRL_RX -- requirements
Module: awsctrl_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame.
REQ-002 The block SHALL have parameter NEUTRAL, default 8'h7F, giving the channel value after reset and after timeout.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 24'd10_000_000, giving the clk cycles without a good frame before a channel reverts.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-006 The block SHALL have port sclk, input, 1 bit: the serial clock, asynchronous to clk.
REQ-007 The block SHALL have port sdi, input, 1 bit: serial data, MSB first.
REQ-008 The block SHALL have port cs_n, input, 3 bits: channel select, active low, one bit low per frame.
REQ-009 The block SHALL have port ch0_val, output, DATA_W bits: the last good value for channel 0 (cs_n=3'b110).
REQ-010 The block SHALL have port ch1_val, output, DATA_W bits: the last good value for channel 1 (cs_n=3'b101).
REQ-011 The block SHALL have port ch2_val, output, DATA_W bits: the last good value for channel 2 (cs_n=3'b011).
REQ-012 The block SHALL have port upd, output, 3 bits: a one-cycle pulse per channel on a good frame.
REQ-013 The block SHALL have port frm_err, output, 1 bit: a one-cycle pulse on a rejected frame.
REQ-014 The block SHALL have port tmo, output, 3 bits: a level per channel, high while that channel is timed out.

Function
REQ-015 The block SHALL pass sclk, sdi and cs_n each through a 2-flop synchronizer on clk, plus one delay stage for edge detection.
REQ-016 The block SHALL implement FSM states IDLE, SHIFT and DONE.
  - IDLE -> SHIFT when synchronized cs_n leaves 3'b111.
  - SHIFT -> DONE when cs_n returns to 3'b111.
  - DONE -> IDLE after one cycle.
REQ-017 On entry to SHIFT the block SHALL latch cs_n as the frame channel and clear the bit counter and shift register.
REQ-018 In SHIFT, the block SHALL shift in synchronized sdi on each synchronized sclk rising edge.
  - The shift register is DATA_W bits wide, left shift, LSB gets new bit.
  - The bit counter saturates at DATA_W+1.
REQ-019 In DONE, a frame SHALL be good only if the bit count equals DATA_W and the latched channel is one of 3'b110, 3'b101, 3'b011.
REQ-020 For a good frame, the block SHALL load the shift register into the selected chN_val and pulse upd[N] for exactly one cycle.
REQ-021 For a non-good frame, the block SHALL leave all chN_val unchanged, pulse frm_err for one cycle, and assert no upd bit.
REQ-022 If cs_n changes to a value other than the latched channel or 3'b111 during SHIFT, the frame SHALL be marked bad; the FSM waits for 3'b111, then DONE reports frm_err.
REQ-023 An sclk edge and cs_n deassertion detected in the same cycle SHALL NOT count that bit.
REQ-024 Timing of upd/chN_val:
  - Edge k: first clk edge sampling cs_n pin high.
  - Edge k+2: DONE is entered.
  - Edge k+3: upd/chN_val are registered.
REQ-025 Each channel SHALL have a timeout counter that clears on its upd and saturates at TIMEOUT_CYC.
REQ-026 When a timeout counter reaches TIMEOUT_CYC, the block SHALL load NEUTRAL into chN_val and set tmo[N] high until the next good frame for that channel.
REQ-027 A good frame arriving in the same cycle as the timeout SHALL win: the new value is loaded and tmo stays low.

Reset
REQ-028 On rst_n low, asynchronously: FSM=IDLE, synchronizers to idle (sclk=0, sdi=0, cs_n=3'b111), chN_val=NEUTRAL, upd=0, frm_err=0, tmo=0, counters=0.
REQ-029 Reset deasserted mid-frame SHALL NOT produce a frame: the FSM waits in IDLE for cs_n=3'b111 before accepting a new frame start.

Configuration
REQ-030 With macro AWSCTRL_RX_TIMEOUT_EN defined, the block SHALL implement REQ-025..REQ-027.
REQ-031 Without AWSCTRL_RX_TIMEOUT_EN, the block SHALL omit the timeout counters, hold tmo at 3'b000, and hold chN_val until the next good frame or reset.

Verification
REQ-032 cs_n=3'b101, 8 sclk pulses with sdi=0xA5, cs_n=3'b111 -> ch1_val=8'hA5, upd=3'b010 for one cycle, 3 clk after cs_n rise; ch0/ch2 stay 8'h7F.
REQ-033 cs_n=3'b110, 7 bits then deassert -> frm_err pulse once, ch0_val unchanged, upd=0; repeat with 9 bits -> same.
REQ-034 cs_n=3'b100, 8 bits 0x3C -> frm_err, no channel changes.
REQ-035 cs_n switches from 3'b011 to 3'b110 mid-frame -> frm_err after final 3'b111, no upd.
REQ-036 TIMEOUT_CYC=100, AWSCTRL_RX_TIMEOUT_EN defined, good frame 0x10 on ch2, then idle 100 cycles -> ch2_val=8'h7F, tmo[2]=1; next good frame 0x20 -> ch2_val=8'h20, tmo[2]=0; same test without macro -> ch2_val holds 8'h10.
REQ-037 rst_n pulsed low after 4 bits of a frame -> all outputs reset; remaining bits and cs_n rise produce no upd and no frm_err.

Source files
------------

// File: rtl/awsctrl_rx.sv
// awsctrl_rx: three-channel serial command receiver.
// Samples an asynchronous sclk/sdi/cs_n serial link on clk, assembles DATA_W-bit
// MSB-first frames, and holds the last good value per channel.
// Optional per-channel timeout reverts a channel to NEUTRAL when its frames stop;
// it is built only when AWSCTRL_RX_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, sdi, cs_n     serial clock, data (MSB first), active-low channel select
//   ch0_val..ch2_val    last good value for channel 0/1/2 (cs_n 110/101/011)
//   upd                 one-cycle pulse per channel on a good frame
//   frm_err             one-cycle pulse on a rejected frame
//   tmo                 per-channel level, high while that channel is timed out
module awsctrl_rx #(
  parameter int unsigned        DATA_W      = 8,
  parameter logic [DATA_W-1:0]  NEUTRAL     = DATA_W'(8'h7F),
  parameter logic [23:0]        TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sdi,
  input  logic [2:0]        cs_n,
  output logic [DATA_W-1:0] ch0_val,
  output logic [DATA_W-1:0] ch1_val,
  output logic [DATA_W-1:0] ch2_val,
  output logic [2:0]        upd,
  output logic              frm_err,
  output logic [2:0]        tmo
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
  localparam logic [2:0]       CS_IDLE  = 3'b111;
  localparam logic [2:0]       CS_CH0   = 3'b110;
  localparam logic [2:0]       CS_CH1   = 3'b101;
  localparam logic [2:0]       CS_CH2   = 3'b011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Synchronizers; sclk carries an extra delay stage for rising-edge detection
  logic       sclk_s1, sclk_s2, sclk_d;
  logic       sdi_s1, sdi_s2;
  logic [2:0] cs_s1, cs_s2;
  logic [1:0] settle;
  logic       sclk_rise_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      sdi_s1  <= 1'b0;
      sdi_s2  <= 1'b0;
      cs_s1   <= CS_IDLE;
      cs_s2   <= CS_IDLE;
      settle  <= 2'b00;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      settle  <= {settle[0], 1'b1};
    end
  end

  assign sclk_rise_c = sclk_s2 & ~sclk_d;

  // Frame FSM state
  state_t              state, state_nx;
  logic                armed, armed_nx;
  logic [2:0]          chan, chan_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [DATA_W-1:0]   sreg, sreg_nx;
  logic                bad, bad_nx;
  logic [2:0]          upd_c;
  logic                err_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      chan  <= CS_IDLE;
      cnt   <= '0;
      sreg  <= '0;
      bad   <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= armed_nx;
      chan  <= chan_nx;
      cnt   <= cnt_nx;
      sreg  <= sreg_nx;
      bad   <= bad_nx;
    end
  end

  // Next-state and frame decode. A frame start is only accepted once an idle
  // cs_n has been seen after reset (settle covers the synchronizer flush), so
  // a reset released mid-frame never produces a partial frame.
  always_comb begin
    state_nx = state;
    armed_nx = armed;
    chan_nx  = chan;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    bad_nx   = bad;
    upd_c    = 3'b000;
    err_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!armed) begin
          if (settle[1] && (cs_s2 == CS_IDLE)) armed_nx = 1'b1;
        end else if (cs_s2 != CS_IDLE) begin
          state_nx = SHIFT;
          chan_nx  = cs_s2;
          cnt_nx   = '0;
          sreg_nx  = '0;
          bad_nx   = 1'b0;
        end
      end
      SHIFT: begin
        // Deassert wins over a coincident sclk edge: that bit is dropped
        if (cs_s2 == CS_IDLE) begin
          state_nx = DONE;
        end else begin
          if (cs_s2 != chan) bad_nx = 1'b1;
          if (sclk_rise_c) begin
            sreg_nx = {sreg[DATA_W-2:0], sdi_s2};
            if (cnt != CNT_SAT) cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (!bad && (cnt == CNT_FULL)) begin
          case (chan)
            CS_CH0:  upd_c = 3'b001;
            CS_CH1:  upd_c = 3'b010;
            CS_CH2:  upd_c = 3'b100;
            default: upd_c = 3'b000;
          endcase
        end
        err_c = (upd_c == 3'b000);
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output registers
  logic [DATA_W-1:0] ch_val [3];

`ifdef AWSCTRL_RX_TIMEOUT_EN
  logic [23:0] tcnt [3];

  // Per-channel idle counters, saturating at TIMEOUT_CYC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 3; n++) tcnt[n] <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (upd_c[n])                   tcnt[n] <= '0;
        else if (tcnt[n] != TIMEOUT_CYC) tcnt[n] <= tcnt[n] + 24'd1;
      end
    end
  end

  // A good frame takes priority over a coincident timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 3; n++) ch_val[n] <= NEUTRAL;
      tmo <= 3'b000;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (upd_c[n]) begin
          ch_val[n] <= sreg;
          tmo[n]    <= 1'b0;
        end else if (tcnt[n] == TIMEOUT_CYC) begin
          ch_val[n] <= NEUTRAL;
          tmo[n]    <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 3; n++) ch_val[n] <= NEUTRAL;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (upd_c[n]) ch_val[n] <= sreg;
      end
    end
  end

  assign tmo = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd     <= 3'b000;
      frm_err <= 1'b0;
    end else begin
      upd     <= upd_c;
      frm_err <= err_c;
    end
  end

  assign ch0_val = ch_val[0];
  assign ch1_val = ch_val[1];
  assign ch2_val = ch_val[2];

endmodule
